// File: rtl/hpdcache_mem_resp_demux_rt.sv
// ID-routed memory response demux: routing table maps response ID to requester port, per-port elastic FIFO.
// Latency: one cycle from accepted beat to mem_resp_valid_o. Backpressure: stall only when the target FIFO is full.
// Optional perf outputs behind HPDCACHE_RESP_DEMUX_PERF_EN.
module hpdcache_mem_resp_demux_rt #(
  parameter int unsigned N          = 2,
  parameter int unsigned RESP_W     = 64,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned PORTID_W   = $clog2(N)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rt_wr_valid_i,
  output logic                  rt_wr_ready_o,
  input  logic [ID_W-1:0]       rt_wr_id_i,
  input  logic [PORTID_W-1:0]   rt_wr_portid_i,
  input  logic                  mem_resp_valid_i,
  output logic                  mem_resp_ready_o,
  input  logic [ID_W-1:0]       mem_resp_id_i,
  input  logic                  mem_resp_last_i,
  input  logic [RESP_W-1:0]     mem_resp_i,
  output logic [N-1:0]          mem_resp_valid_o,
  input  logic [N-1:0]          mem_resp_ready_i,
  output logic [N*RESP_W-1:0]   mem_resp_o,
  output logic                  err_unmapped_o
`ifdef HPDCACHE_RESP_DEMUX_PERF_EN
  ,
  output logic [N-1:0]          perf_stall_o,
  output logic [15:0]           perf_unmapped_cnt_o
`endif
);

  localparam int unsigned RT_DEPTH = 2**ID_W;
  localparam int unsigned AW       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned LW       = AW - 1;

  logic [RT_DEPTH-1:0] rt_valid;
  logic [PORTID_W-1:0] rt_port [RT_DEPTH];
  logic [N-1:0]        fifo_full;
  logic [N-1:0]        push;
  logic [PORTID_W-1:0] tgt;
  logic                hit;
  logic                resp_acc;
  logic                resp_drop;
  logic                err_q;

  // Entries owned by an out-of-range port are treated exactly like unallocated IDs.
  always_comb begin
    tgt              = rt_port[mem_resp_id_i];
    hit              = rt_valid[mem_resp_id_i] && (int'(tgt) < int'(N));
    mem_resp_ready_o = hit ? ~fifo_full[tgt] : 1'b1;
    resp_acc         = mem_resp_valid_i & mem_resp_ready_o;
    resp_drop        = resp_acc & ~hit;
  end

  assign rt_wr_ready_o  = ~rt_valid[rt_wr_id_i];
  assign err_unmapped_o = err_q;

  // Write needs a clear entry and free needs a set one, so they can never target the same ID in one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rt_valid <= '0;
      err_q    <= 1'b0;
    end else begin
      if (resp_acc && mem_resp_last_i && rt_valid[mem_resp_id_i])
        rt_valid[mem_resp_id_i] <= 1'b0;
      if (rt_wr_valid_i && rt_wr_ready_o)
        rt_valid[rt_wr_id_i] <= 1'b1;
      err_q <= resp_drop;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rt_wr_valid_i && rt_wr_ready_o)
      rt_port[rt_wr_id_i] <= rt_wr_portid_i;
  end

  for (genvar k = 0; k < int'(N); k++) begin : g_port
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [RESP_W-1:0] mem [FIFO_DEPTH];
    logic              empty;
    logic              pop;

    assign push[k]      = resp_acc & hit & (tgt == PORTID_W'(k));
    assign empty        = (wr_ptr == rd_ptr);
    assign fifo_full[k] = (wr_ptr[AW-1] != rd_ptr[AW-1]) &&
                          (wr_ptr[LW-1:0] == rd_ptr[LW-1:0]);
    assign pop          = ~empty & mem_resp_ready_i[k];

    assign mem_resp_valid_o[k]              = ~empty;
    assign mem_resp_o[k*RESP_W +: RESP_W]   = mem[rd_ptr[LW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[k]) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (push[k])
        mem[wr_ptr[LW-1:0]] <= mem_resp_i;
    end

`ifdef HPDCACHE_RESP_DEMUX_PERF_EN
    assign perf_stall_o[k] = mem_resp_valid_i & hit & (tgt == PORTID_W'(k)) & fifo_full[k];
`endif
  end

`ifdef HPDCACHE_RESP_DEMUX_PERF_EN
  logic [15:0] unmapped_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      unmapped_cnt_q <= '0;
    else if (resp_drop && (unmapped_cnt_q != 16'hFFFF))
      unmapped_cnt_q <= unmapped_cnt_q + 16'd1;
  end

  assign perf_unmapped_cnt_o = unmapped_cnt_q;
`endif

endmodule

// File: tb/tb_hpdcache_mem_resp_demux_rt.sv
// Directed bench for hpdcache_mem_resp_demux_rt (N=2, RESP_W=64, ID_W=4, FIFO_DEPTH=2).
module tb_hpdcache_mem_resp_demux_rt;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         rt_wr_valid_i;
  logic         rt_wr_ready_o;
  logic [3:0]   rt_wr_id_i;
  logic [0:0]   rt_wr_portid_i;
  logic         mem_resp_valid_i;
  logic         mem_resp_ready_o;
  logic [3:0]   mem_resp_id_i;
  logic         mem_resp_last_i;
  logic [63:0]  mem_resp_i;
  logic [1:0]   mem_resp_valid_o;
  logic [1:0]   mem_resp_ready_i;
  logic [127:0] mem_resp_o;
  logic         err_unmapped_o;
`ifdef HPDCACHE_RESP_DEMUX_PERF_EN
  logic [1:0]   perf_stall_o;
  logic [15:0]  perf_unmapped_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  hpdcache_mem_resp_demux_rt #(
    .N(2), .RESP_W(64), .ID_W(4), .FIFO_DEPTH(2)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .rt_wr_valid_i   (rt_wr_valid_i),
    .rt_wr_ready_o   (rt_wr_ready_o),
    .rt_wr_id_i      (rt_wr_id_i),
    .rt_wr_portid_i  (rt_wr_portid_i),
    .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_ready_o(mem_resp_ready_o),
    .mem_resp_id_i   (mem_resp_id_i),
    .mem_resp_last_i (mem_resp_last_i),
    .mem_resp_i      (mem_resp_i),
    .mem_resp_valid_o(mem_resp_valid_o),
    .mem_resp_ready_i(mem_resp_ready_i),
    .mem_resp_o      (mem_resp_o),
    .err_unmapped_o  (err_unmapped_o)
`ifdef HPDCACHE_RESP_DEMUX_PERF_EN
    ,
    .perf_stall_o       (perf_stall_o),
    .perf_unmapped_cnt_o(perf_unmapped_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic alloc(input logic [3:0] id, input logic [0:0] port);
    rt_wr_valid_i  = 1'b1;
    rt_wr_id_i     = id;
    rt_wr_portid_i = port;
    tick();
    rt_wr_valid_i  = 1'b0;
  endtask

  task automatic beat(input logic [3:0] id, input logic last, input logic [63:0] dat);
    mem_resp_valid_i = 1'b1;
    mem_resp_id_i    = id;
    mem_resp_last_i  = last;
    mem_resp_i       = dat;
  endtask

  initial begin
    rst_ni           = 1'b0;
    rt_wr_valid_i    = 1'b0;
    rt_wr_id_i       = 4'd0;
    rt_wr_portid_i   = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_id_i    = 4'd0;
    mem_resp_last_i  = 1'b0;
    mem_resp_i       = 64'd0;
    mem_resp_ready_i = 2'b11;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
    chk("rst_valid_o", 64'(mem_resp_valid_o), 64'd0);
    chk("rst_err", 64'(err_unmapped_o), 64'd0);
    chk("rst_rt_wr_ready", 64'(rt_wr_ready_o), 64'd1);
    chk("rst_resp_ready", 64'(mem_resp_ready_o), 64'd1);

    // single beat ID 3 -> port 1
    rt_wr_valid_i = 1'b1; rt_wr_id_i = 4'd3; rt_wr_portid_i = 1'b1;
    #1 chk("t1_alloc_ready", 64'(rt_wr_ready_o), 64'd1);
    tick();
    rt_wr_valid_i = 1'b0;
    #1 chk("t1_id3_busy", 64'(rt_wr_ready_o), 64'd0);
    beat(4'd3, 1'b1, 64'hA5);
    #1 chk("t1_resp_ready", 64'(mem_resp_ready_o), 64'd1);
    chk("t1_no_early_valid", 64'(mem_resp_valid_o), 64'd0);
    tick();
    mem_resp_valid_i = 1'b0;
    #1;
    chk("t1_valid_o", 64'(mem_resp_valid_o), 64'b10);
    chk("t1_data", mem_resp_o[127:64], 64'hA5);
    chk("t1_id3_freed", 64'(rt_wr_ready_o), 64'd1);
    tick();
    chk("t1_drained", 64'(mem_resp_valid_o), 64'd0);

    // fill port 0, third beat stalls, in-order drain
    mem_resp_ready_i = 2'b10;
    alloc(4'd1, 1'b0);
    beat(4'd1, 1'b0, 64'd1);
    #1 chk("t2_b1_ready", 64'(mem_resp_ready_o), 64'd1);
    tick();
    beat(4'd1, 1'b0, 64'd2);
    #1 chk("t2_b2_ready", 64'(mem_resp_ready_o), 64'd1);
    tick();
    beat(4'd1, 1'b1, 64'd3);
    #1 chk("t2_b3_stall", 64'(mem_resp_ready_o), 64'd0);
    chk("t2_head1", mem_resp_o[63:0], 64'd1);
    mem_resp_ready_i = 2'b11;
    #1 chk("t2_ready_indep_of_out", 64'(mem_resp_ready_o), 64'd0);
    tick();
    chk("t2_b3_now_ready", 64'(mem_resp_ready_o), 64'd1);
    chk("t2_head2", mem_resp_o[63:0], 64'd2);
    tick();
    mem_resp_valid_i = 1'b0;
    #1 chk("t2_head3", mem_resp_o[63:0], 64'd3);
    chk("t2_valid3", 64'(mem_resp_valid_o), 64'b01);
    rt_wr_id_i = 4'd1;
    #1 chk("t2_id1_freed", 64'(rt_wr_ready_o), 64'd1);
    tick();
    chk("t2_empty", 64'(mem_resp_valid_o), 64'd0);

    // head-of-line: ID 2 beat waits behind a stalled port-0 beat, then bypasses blocked port 0
    mem_resp_ready_i = 2'b10;
    alloc(4'd1, 1'b0);
    alloc(4'd2, 1'b1);
    beat(4'd1, 1'b0, 64'h11); tick();
    beat(4'd1, 1'b0, 64'h12); tick();
    beat(4'd1, 1'b1, 64'h13);
    #1 chk("t3_stall_a", 64'(mem_resp_ready_o), 64'd0);
    tick();
    chk("t3_stall_b", 64'(mem_resp_ready_o), 64'd0);
    chk("t3_port1_idle", 64'(mem_resp_valid_o), 64'b01);
    mem_resp_ready_i = 2'b11;
    tick();
    mem_resp_ready_i = 2'b10;
    #1 chk("t3_unstall", 64'(mem_resp_ready_o), 64'd1);
    tick();
    beat(4'd2, 1'b1, 64'h22);
    #1 chk("t3_id2_ready", 64'(mem_resp_ready_o), 64'd1);
    tick();
    mem_resp_valid_i = 1'b0;
    #1 chk("t3_both_valid", 64'(mem_resp_valid_o), 64'b11);
    chk("t3_p1_data", mem_resp_o[127:64], 64'h22);
    chk("t3_p0_data", mem_resp_o[63:0], 64'h12);
    mem_resp_ready_i = 2'b11;
    tick();
    chk("t3_p0_next", mem_resp_o[63:0], 64'h13);
    chk("t3_valid_after", 64'(mem_resp_valid_o), 64'b01);
    tick();
    chk("t3_empty", 64'(mem_resp_valid_o), 64'd0);

    // unmapped ID 7
    beat(4'd7, 1'b1, 64'h77);
    #1 chk("t4_ready", 64'(mem_resp_ready_o), 64'd1);
    chk("t4_err_not_early", 64'(err_unmapped_o), 64'd0);
    tick();
    mem_resp_valid_i = 1'b0;
    #1 chk("t4_err_pulse", 64'(err_unmapped_o), 64'd1);
    chk("t4_no_valid", 64'(mem_resp_valid_o), 64'd0);
    tick();
    chk("t4_err_clear", 64'(err_unmapped_o), 64'd0);

    // re-allocate ID 3 in the same cycle as its last beat
    alloc(4'd3, 1'b0);
    beat(4'd3, 1'b1, 64'h33);
    rt_wr_valid_i = 1'b1; rt_wr_id_i = 4'd3; rt_wr_portid_i = 1'b1;
    #1 chk("t5_wr_blocked", 64'(rt_wr_ready_o), 64'd0);
    chk("t5_resp_ready", 64'(mem_resp_ready_o), 64'd1);
    tick();
    mem_resp_valid_i = 1'b0;
    #1 chk("t5_wr_ready_next", 64'(rt_wr_ready_o), 64'd1);
    chk("t5_old_route", 64'(mem_resp_valid_o), 64'b01);
    chk("t5_old_data", mem_resp_o[63:0], 64'h33);
    tick();
    rt_wr_valid_i = 1'b0;
    #1 chk("t5_realloc_busy", 64'(rt_wr_ready_o), 64'd0);
    beat(4'd3, 1'b1, 64'h55);
    tick();
    mem_resp_valid_i = 1'b0;
    #1 chk("t5_new_route", 64'(mem_resp_valid_o), 64'b10);
    chk("t5_new_data", mem_resp_o[127:64], 64'h55);
    tick();

    // reset with buffered beats
    mem_resp_ready_i = 2'b00;
    alloc(4'd5, 1'b0);
    beat(4'd5, 1'b0, 64'hA1); tick();
    beat(4'd5, 1'b0, 64'hA2); tick();
    mem_resp_valid_i = 1'b0;
    #1 chk("t6_buffered", 64'(mem_resp_valid_o), 64'b01);
    rst_ni = 1'b0;
    #1 chk("t6_rst_valid", 64'(mem_resp_valid_o), 64'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    mem_resp_ready_i = 2'b11;
    rt_wr_id_i = 4'd5;
    #1 chk("t6_rt_cleared", 64'(rt_wr_ready_o), 64'd1);
    chk("t6_still_empty", 64'(mem_resp_valid_o), 64'd0);
    beat(4'd5, 1'b1, 64'hA3);
    #1 chk("t6_resp_ready", 64'(mem_resp_ready_o), 64'd1);
    tick();
    mem_resp_valid_i = 1'b0;
    #1 chk("t6_unmapped_err", 64'(err_unmapped_o), 64'd1);
    chk("t6_no_valid", 64'(mem_resp_valid_o), 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
